convolution_3x3: RTL and testbench
==================================

Name: convolution_3x3

Overview:
- Pipelined 3x3 convolution engine for the CNN datapath.
- Each accepted beat takes one 3x3 unsigned pixel patch, a signed 3x3 kernel and a signed bias.
- Computes the multiply-accumulate, adds the bias, applies an arithmetic right shift, then ReLU plus saturation.
- Result is one 10-bit unsigned output pixel. Fully pipelined: one patch per clock, fixed latency, no backpressure.

Parameters:
- SHIFT, 0, arithmetic right-shift amount applied to the biased sum before clamping (legal range 0..12).
- OUT_MAX, 1023, saturation ceiling of output_pixel; must fit in 10 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input_patch/kernel/bias are valid this cycle.
- input_patch  input  72  nine unsigned 8-bit pixels.
  - Element [r][c] (r,c in 0..2) occupies bits (r*3+c)*8 +: 8.
- kernel  input  72  nine signed two's-complement 8-bit weights, same packing as input_patch.
- bias  input  8  signed two's-complement bias.
- out_valid  output  1  output_pixel holds a new result.
- output_pixel  output  10  unsigned clamped convolution result.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clk edge.
  - Clears every pipeline register, including valid bits.
  - Outputs while rst is high and on the first cycle after: out_valid=0, output_pixel=0.
  - Reset mid-operation discards all in-flight beats; none emerge after rst deasserts.
- Arithmetic, all signed with no intermediate overflow:
  - p[i] = zero-extended pixel times sign-extended weight (17-bit signed).
  - sum = sum of p[0..8] plus sign-extended bias, held in at least 22 bits signed.
  - shifted = sum >>> SHIFT (arithmetic, truncation toward minus infinity).
  - output_pixel = 0 if shifted < 0; OUT_MAX if shifted > OUT_MAX; otherwise shifted[9:0].
- Pipeline, registered at every stage:
  - S1: register the nine products plus bias and in_valid.
  - S2: three row partial sums; bias is carried alongside.
  - S3: final sum, bias add, shift, clamp; drive output registers.
- Latency: a beat with in_valid=1 at edge N produces out_valid=1 with its result after edge N+3.
- Throughput: one beat per cycle, back-to-back with no bubbles. No stall input exists.
- When in_valid=0, the valid bit propagates as 0. output_pixel holds its last value while out_valid=0; it is not re-zeroed.
- Input fields are sampled only when in_valid=1. Values on idle cycles must not affect any output.

Optional Feature:
- Macro: CONV_ROUND_EN.
  - Defined, with SHIFT>0: add 2^(SHIFT-1) to sum before the shift (round half up), then clamp as normal.
  - Defined, with SHIFT=0: no effect.
  - Not defined: pure truncating arithmetic shift.
- Latency and ports are identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random in_valid/data -> out_valid=0 and output_pixel=0 during reset and for 3 cycles after, unless new valid beats are applied.
- All-ones: SHIFT=0, patch all 1, kernel all 1, bias 0, single beat -> out_valid high exactly 3 cycles later with output_pixel=9.
- Identity kernel: kernel center=1 and others 0, center pixel 200, bias 5 -> 205. Same with bias=-10 -> 190.
- Saturation: patch all 255, kernel all 127, bias 127 -> 1023. Patch all 255, kernel all -128, bias 0 -> 0 (ReLU).
- Shift and rounding with SHIFT=2: patch all 1, kernel all 1, bias -2, giving sum 7:
  - Without macro -> 1.
  - With CONV_ROUND_EN -> 2.
  - With bias -10 (sum -1) -> 0 in both builds.
- Streaming: 5 consecutive valid beats with identity kernel and center pixels 10,20,30,40,50, then a one-cycle in_valid=0 gap, then center 60:
  - Outputs 10,20,30,40,50 on consecutive cycles, then out_valid=0 for one cycle, then 60.
  - Asserting rst during the stream suppresses all remaining outputs.

Source files
------------

// File: rtl/convolution_3x3.sv
// Pipelined 3x3 convolution: MAC + bias, arithmetic shift, ReLU and saturation.
// Optional build macro CONV_ROUND_EN adds round-half-up before the shift.
module convolution_3x3 #(
    parameter int SHIFT   = 0,
    parameter int OUT_MAX = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [71:0] input_patch,
    input  logic [71:0] kernel,
    input  logic [7:0]  bias,
    output logic        out_valid,
    output logic [9:0]  output_pixel
);

    // Handshake: valid-only stream. A beat is taken on every edge where in_valid=1;
    // there is no ready, and out_valid pulses for one cycle per result after a fixed latency.

    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
`ifdef CONV_ROUND_EN
    localparam logic signed [23:0] RND = (SHIFT > 0) ? (24'sd1 <<< RSH) : 24'sd0;
`else
    localparam logic signed [23:0] RND = 24'sd0;
`endif
    localparam logic signed [23:0] MAX_S = 24'(OUT_MAX);

    logic signed [16:0] prod_d [9];
    logic signed [16:0] prod_q [9];
    logic signed [7:0]  bias1_q;
    logic signed [7:0]  bias2_q;
    logic signed [19:0] row_q  [3];
    logic signed [23:0] sum_q;
    logic signed [23:0] shifted;
    logic        [9:0]  clamp_d;
    logic               v1_q;
    logic               v2_q;
    logic               v3_q;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            prod_d[i] = $signed({9'd0, input_patch[i*8 +: 8]}) *
                        $signed({{9{kernel[i*8+7]}}, kernel[i*8 +: 8]});
        end
    end

    // Stage 1: products; input fields are only captured on valid beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            bias1_q <= '0;
            for (int i = 0; i < 9; i++) prod_q[i] <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                bias1_q <= bias;
                for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
            end
        end
    end

    // Stage 2: row partial sums, bias carried alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q    <= 1'b0;
            bias2_q <= '0;
            for (int r = 0; r < 3; r++) row_q[r] <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                bias2_q <= bias1_q;
                for (int r = 0; r < 3; r++) begin
                    row_q[r] <= 20'(prod_q[r*3]) + 20'(prod_q[r*3+1]) + 20'(prod_q[r*3+2]);
                end
            end
        end
    end

    // Stage 3: full biased sum (with rounding offset when enabled).
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q  <= 1'b0;
            sum_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) begin
                sum_q <= 24'(row_q[0]) + 24'(row_q[1]) + 24'(row_q[2]) + 24'(bias2_q) + RND;
            end
        end
    end

    always_comb begin
        shifted = sum_q >>> SHIFT;
        clamp_d = shifted[9:0];
        if (shifted < 24'sd0) begin
            clamp_d = 10'd0;
        end else if (shifted > MAX_S) begin
            clamp_d = 10'(OUT_MAX);
        end
    end

    // Output register holds its value between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            output_pixel <= '0;
        end else begin
            out_valid <= v3_q;
            if (v3_q) output_pixel <= clamp_d;
        end
    end

endmodule

// File: tb/tb_convolution_3x3.sv
// Randomized scoreboard bench for convolution_3x3; runs SHIFT=0 and SHIFT=2 instances side by side.
module tb_convolution_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [71:0] input_patch = '0;
    logic [71:0] kernel = '0;
    logic [7:0]  bias = '0;
    logic        out_valid0, out_valid1;
    logic [9:0]  output_pixel0, output_pixel1;

    typedef struct {
        int         due;
        logic [9:0] e0;
        logic [9:0] e1;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       head;
    logic       exp_v;
    logic [9:0] last0 = '0;
    logic [9:0] last1 = '0;
    int         cyc = 0;
    logic       rst_seen = 1'b1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    convolution_3x3 #(.SHIFT(0), .OUT_MAX(1023)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .input_patch(input_patch),
        .kernel(kernel), .bias(bias), .out_valid(out_valid0), .output_pixel(output_pixel0)
    );

    convolution_3x3 #(.SHIFT(2), .OUT_MAX(1023)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .input_patch(input_patch),
        .kernel(kernel), .bias(bias), .out_valid(out_valid1), .output_pixel(output_pixel1)
    );

    // Reference: plain integer convolution, floor division by 2^sh, then clamp.
    function automatic logic [9:0] model(input logic [71:0] p, input logic [71:0] k,
                                         input logic [7:0] b, input int sh);
        int sum, d, q;
        sum = int'($signed(b));
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                sum += int'(p[(r*3+c)*8 +: 8]) * int'($signed(k[(r*3+c)*8 +: 8]));
            end
        end
`ifdef CONV_ROUND_EN
        if (sh > 0) sum += (1 << (sh - 1));
`endif
        d = 1 << sh;
        q = sum / d;
        if ((sum % d != 0) && (sum < 0)) q -= 1;
        if (q < 0) return 10'd0;
        if (q > 1023) return 10'd1023;
        return 10'(q);
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] v);
        return {9{v}};
    endfunction

    function automatic logic [71:0] rnd72();
        return 72'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [71:0] small_kernel();
        logic [71:0] k;
        for (int i = 0; i < 9; i++) k[i*8 +: 8] = 8'($signed($urandom_range(0, 4)) - 2);
        return k;
    endfunction

    // Identity kernel and a random patch with the chosen centre pixel.
    function automatic logic [71:0] ident();
        logic [71:0] k;
        k = '0;
        k[39:32] = 8'd1;
        return k;
    endfunction

    function automatic logic [71:0] centre(input logic [7:0] v);
        logic [71:0] p;
        p = rnd72();
        p[39:32] = v;
        return p;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [71:0] p, input logic [71:0] k,
                        input logic [7:0] b);
        in_valid    = v;
        input_patch = p;
        kernel      = k;
        bias        = b;
        if (v && !rst) exp_q.push_back('{cyc + 4, model(p, k, b, 0), model(p, k, b, 2)});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, rnd72(), rnd72(), 8'($urandom()));
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) beat(1'($urandom()), rnd72(), rnd72(), 8'($urandom()));
        rst = 1'b0;
    endtask

    // Monitor: pops an expectation only on the cycle it is due.
    always @(negedge clk) begin
        if (rst_seen) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc + 4) void'(exp_q.pop_front());
            chk("rst_valid0", int'(out_valid0), 0);
            chk("rst_valid1", int'(out_valid1), 0);
            chk("rst_pixel0", int'(output_pixel0), 0);
            chk("rst_pixel1", int'(output_pixel1), 0);
            last0 = '0;
            last1 = '0;
        end else begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("valid0", int'(out_valid0), int'(exp_v));
            chk("valid1", int'(out_valid1), int'(exp_v));
            if (exp_v) begin
                head = exp_q.pop_front();
                chk("pixel_shift0", int'(output_pixel0), int'(head.e0));
                chk("pixel_shift2", int'(output_pixel1), int'(head.e1));
                last0 = head.e0;
                last1 = head.e1;
            end else begin
                chk("hold0", int'(output_pixel0), int'(last0));
                chk("hold1", int'(output_pixel1), int'(last1));
            end
        end
    end

    initial begin
        #1;
        do_reset(2);
        idle(3);

        beat(1'b1, fill(8'd1), fill(8'd1), 8'd0);
        idle(4);
        beat(1'b1, centre(8'd200), ident(), 8'd5);
        beat(1'b1, centre(8'd200), ident(), 8'hf6);
        beat(1'b1, fill(8'd255), fill(8'd127), 8'd127);
        beat(1'b1, fill(8'd255), fill(8'h80), 8'd0);
        beat(1'b1, fill(8'd1), fill(8'd1), 8'hfe);
        beat(1'b1, fill(8'd1), fill(8'd1), 8'hf6);
        idle(2);

        for (int i = 1; i <= 5; i++) beat(1'b1, centre(8'(i * 10)), ident(), 8'd0);
        idle(1);
        beat(1'b1, centre(8'd60), ident(), 8'd0);
        idle(5);

        for (int i = 1; i <= 3; i++) beat(1'b1, centre(8'(i * 10)), ident(), 8'd0);
        do_reset(2);
        idle(5);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset($urandom_range(1, 2));
            end else if ($urandom_range(0, 1) == 0) begin
                beat($urandom_range(0, 9) < 7, rnd72(), small_kernel(), 8'($urandom()));
            end else begin
                beat($urandom_range(0, 9) < 7, rnd72(), rnd72(), 8'($urandom()));
            end
        end
        idle(6);

        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
